// File: rtl/bidir_line_responder.sv
// rtl/bidir_line_responder.sv - half-duplex single-wire byte responder
// Receives one start/8-data/stop frame on Dio, then answers on the same wire after a released-line turnaround.
module bidir_line_responder #(
  parameter int BIT_CYC  = 4,
  parameter int TURN_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        Dio,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       drive_en,
  output logic       busy
);

  localparam int CNT_TOP = (BIT_CYC > TURN_CYC) ? BIT_CYC : TURN_CYC;
  localparam int CW      = $clog2(CNT_TOP + 1);
  localparam logic [CW-1:0] C_HALF_LAST = CW'(BIT_CYC / 2 - 1);
  localparam logic [CW-1:0] C_BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] C_TURN_LAST = CW'(TURN_CYC);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RX_START,
    S_RX_DATA,
    S_RX_STOP,
    S_RX_WAITHI,
    S_TURN,
    S_TX_START,
    S_TX_DATA,
    S_TX_STOP
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_sync1, r_sync2, r_line_prev;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_rx_sr, w_rx_sr_nxt;
  logic [7:0]    r_tx_sr, w_tx_sr_nxt;
  logic [7:0]    r_rx_data, w_rx_data_nxt;
  logic          r_rx_valid, w_rx_valid_nxt;
  logic          r_frame_err, w_frame_err_nxt;
  logic          r_drive_en, w_drive_en_nxt;
  logic          r_tx_bit, w_tx_bit_nxt;
  logic          w_line_s, w_bit_last;

  assign w_line_s   = r_sync2;
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_bit_last = (r_cnt == C_BIT_LAST);

  // Both drive controls come straight from flops so Dio never glitches.
  assign Dio       = r_drive_en ? r_tx_bit : 1'bz;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign drive_en  = r_drive_en;
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_line_prev <= 1'b1;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_rx_sr     <= '0;
      r_tx_sr     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_drive_en  <= 1'b0;
      r_tx_bit    <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_sync1     <= Dio;
      r_sync2     <= r_sync1;
      r_line_prev <= w_line_s;
      r_cnt       <= w_cnt_nxt;
      r_bit       <= w_bit_nxt;
      r_rx_sr     <= w_rx_sr_nxt;
      r_tx_sr     <= w_tx_sr_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_drive_en  <= w_drive_en_nxt;
      r_tx_bit    <= w_tx_bit_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_bit_nxt       = r_bit;
    w_rx_sr_nxt     = r_rx_sr;
    w_tx_sr_nxt     = r_tx_sr;
    w_rx_data_nxt   = r_rx_data;
    w_rx_valid_nxt  = 1'b0;
    w_frame_err_nxt = 1'b0;
    w_drive_en_nxt  = r_drive_en;
    w_tx_bit_nxt    = r_tx_bit;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_bit_nxt = '0;
        // Only a falling edge starts a frame, so a line still low from before is ignored.
        if (!w_line_s && r_line_prev) w_state_nxt = S_RX_START;
      end
      S_RX_START: begin
        if (r_cnt == C_HALF_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_line_s ? S_IDLE : S_RX_DATA;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_RX_DATA: begin
        if (w_bit_last) begin
          w_cnt_nxt   = '0;
          w_rx_sr_nxt = {w_line_s, r_rx_sr[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_nxt = S_RX_STOP;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_RX_STOP: begin
        if (w_bit_last) begin
          w_cnt_nxt = '0;
          if (w_line_s) begin
            w_rx_data_nxt  = r_rx_sr;
            w_rx_valid_nxt = 1'b1;
            w_tx_sr_nxt    = tx_data;
            w_state_nxt    = S_TURN;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = S_RX_WAITHI;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_RX_WAITHI: begin
        if (w_line_s) w_state_nxt = S_IDLE;
      end
      S_TURN: begin
        if (r_cnt == C_TURN_LAST) begin
          w_cnt_nxt      = '0;
          w_drive_en_nxt = 1'b1;
          w_tx_bit_nxt   = 1'b0;
          w_state_nxt    = S_TX_START;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_TX_START: begin
        if (w_bit_last) begin
          w_cnt_nxt    = '0;
          w_bit_nxt    = '0;
          w_tx_bit_nxt = r_tx_sr[0];
          w_state_nxt  = S_TX_DATA;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_TX_DATA: begin
        if (w_bit_last) begin
          w_cnt_nxt = '0;
          if (r_bit == 3'd7) begin
            w_tx_bit_nxt = 1'b1;
            w_state_nxt  = S_TX_STOP;
          end else begin
            w_bit_nxt    = r_bit + 3'd1;
            w_tx_bit_nxt = r_tx_sr[1];
            w_tx_sr_nxt  = {1'b0, r_tx_sr[7:1]};
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_TX_STOP: begin
        if (w_bit_last) begin
          w_cnt_nxt      = '0;
          w_drive_en_nxt = 1'b0;
          w_tx_bit_nxt   = 1'b1;
          w_state_nxt    = S_IDLE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bidir_line_responder.sv
// tb/tb_bidir_line_responder.sv - bench for bidir_line_responder
// Acts as the line initiator and compares frames and responses against a frame-level reference model.
module tb_bidir_line_responder;

  localparam int BIT_CYC  = 4;
  localparam int TURN_CYC = 2;
  localparam int RESP_LEN = 10 * BIT_CYC;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, drive_en, busy;
  logic       tb_oe, tb_bit;
  wire        Dio;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] model_rx;

  assign Dio = tb_oe ? tb_bit : 1'bz;
  pullup (Dio);

  always #5 clk = ~clk;

  bidir_line_responder #(.BIT_CYC(BIT_CYC), .TURN_CYC(TURN_CYC)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .Dio      (Dio),
    .tx_data  (tx_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .drive_en (drive_en),
    .busy     (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected line level for each driven cycle: start 0, data LSB first, stop 1.
  function automatic logic [RESP_LEN-1:0] resp_model(input logic [7:0] b);
    logic [9:0]          f;
    logic [RESP_LEN-1:0] r;
    f = {1'b1, b, 1'b0};
    for (int j = 0; j < RESP_LEN; j++) r[j] = f[j / BIT_CYC];
    return r;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      tb_oe  = 1'b1;
      tb_bit = f[i];
      repeat (BIT_CYC) @(posedge clk);
      #1;
    end
    tb_oe = 1'b0;
  endtask

  task automatic wait_result(output logic gv, output logic ge);
    gv = 1'b0;
    ge = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      gv = rx_valid;
      ge = frame_err;
      if (gv || ge) break;
    end
  endtask

  task automatic capture_resp(input logic [7:0] txd, input int change_at,
                              input logic [7:0] new_tx, input int abort_at);
    int                  gap, drv, pulses;
    logic [RESP_LEN-1:0] obs;
    gap = 0; drv = 0; pulses = 0; obs = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (drive_en) break;
      pulses += int'(rx_valid) + int'(frame_err);
      gap++;
    end
    check_eq("turn_gap", gap, TURN_CYC);
    if (!drive_en) return;
    for (int i = 0; i < RESP_LEN; i++) begin
      if (i > 0) @(negedge clk);
      if (i == abort_at) begin
        rst = 1'b1;
        #1;
        check_eq("abort_drive_en", drive_en, 0);
        check_eq("abort_dio_released", Dio, 1);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_rx_data", rx_data, 0);
        check_eq("abort_pulses", {rx_valid, frame_err}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_rx = 8'h00;
        return;
      end
      if (i == change_at) tx_data = new_tx;
      obs[i] = Dio;
      drv += int'(drive_en);
      pulses += int'(rx_valid) + int'(frame_err);
    end
    @(negedge clk);
    check_eq("drive_release", drive_en, 0);
    check_eq("drive_len", drv, RESP_LEN);
    check_eq("resp_bits", obs, resp_model(txd));
    check_eq("extra_pulses", pulses, 0);
  endtask

  task automatic good_exchange(input logic [7:0] d, input logic [7:0] txd, input int change_at,
                               input logic [7:0] new_tx, input int abort_at);
    logic gv, ge;
    tx_data = txd;
    send_frame(d, 1'b1);
    wait_result(gv, ge);
    check_eq("rx_valid", gv, 1);
    check_eq("no_frame_err", ge, 0);
    if (gv) begin
      model_rx = d;
      check_eq("rx_data", rx_data, model_rx);
      capture_resp(txd, change_at, new_tx, abort_at);
    end
  endtask

  task automatic bad_frame(input logic [7:0] d);
    logic gv, ge;
    int   drv;
    send_frame(d, 1'b0);
    wait_result(gv, ge);
    check_eq("frame_err", ge, 1);
    check_eq("err_no_valid", gv, 0);
    check_eq("err_rx_data_kept", rx_data, model_rx);
    drv = 0;
    repeat (8) begin
      @(negedge clk);
      drv += int'(drive_en);
    end
    check_eq("err_no_drive", drv, 0);
    check_eq("err_idle", busy, 0);
  endtask

  task automatic false_start();
    logic saw_busy;
    int   drv, pulses;
    @(posedge clk); #1;
    tb_oe = 1'b1; tb_bit = 1'b0;
    @(posedge clk); #1;
    tb_oe = 1'b0;
    saw_busy = 1'b0; drv = 0; pulses = 0;
    repeat (6) begin
      @(negedge clk);
      saw_busy |= busy;
      drv += int'(drive_en);
      pulses += int'(rx_valid) + int'(frame_err);
    end
    check_eq("glitch_seen_busy", saw_busy, 1);
    check_eq("glitch_busy_cleared", busy, 0);
    check_eq("glitch_no_drive", drv, 0);
    check_eq("glitch_no_pulse", pulses, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d, t;
    int         kind;
    rst = 1'b1; tb_oe = 1'b0; tb_bit = 1'b1; tx_data = 8'h00; model_rx = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("reset_rx_data", rx_data, 0);
    check_eq("reset_rx_valid", rx_valid, 0);
    check_eq("reset_frame_err", frame_err, 0);
    check_eq("reset_drive_en", drive_en, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_dio", Dio, 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    good_exchange(8'hA5, 8'h3C, -1, 8'h00, -1);
    false_start();
    bad_frame(8'h5A);
    good_exchange(8'h11, 8'h96, -1, 8'h00, -1);
    good_exchange(8'h42, 8'h3C, -1, 8'h00, 4 * BIT_CYC);
    repeat (3) @(negedge clk);
    good_exchange(8'hFF, 8'h55, -1, 8'h00, -1);
    good_exchange(8'h6E, 8'h3C, 3 * BIT_CYC, 8'hC3, -1);
    good_exchange(8'h01, 8'h81, -1, 8'h00, -1);
    good_exchange(8'h80, 8'h7E, -1, 8'h00, -1);

    for (int n = 0; n < 24; n++) begin
      kind = int'($urandom_range(0, 9));
      d = 8'($urandom);
      t = 8'($urandom);
      if (kind == 0)      false_start();
      else if (kind == 1) bad_frame(d);
      else if (kind == 2) good_exchange(d, t, int'($urandom_range(BIT_CYC, RESP_LEN - 1)), ~t, -1);
      else                good_exchange(d, t, -1, 8'h00, -1);
      repeat (int'($urandom_range(0, 4))) @(posedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bidir_line_responder.md
BIDIR_LINE_RESPONDER -- requirements
Module: bidir_line_responder

Interface
REQ-001 Parameter BIT_CYC, default 4, clocks per bit on the shared line; even and >= 4.
REQ-002 Parameter TURN_CYC, default 2, released-line cycles between the received stop-bit sample and the first driven cycle; >= 1.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 Dio  inout  1  shared half-duplex data line; driven only while drive_en=1, otherwise high-Z; idle level is 1 (external pull-up).
REQ-006 tx_data  input  8  response byte; captured on the rx_valid cycle.
REQ-007 rx_data  output  8  last correctly framed received byte.
REQ-008 rx_valid  output  1  one-cycle pulse; rx_data is new.
REQ-009 frame_err  output  1  one-cycle pulse; stop bit was sampled 0.
REQ-010 drive_en  output  1  1 while this block drives Dio.
REQ-011 busy  output  1  1 in any state other than IDLE.

Function
REQ-012 Dio input passes through a 2-flop synchronizer before use; the FSM sees line_s.
REQ-013 Frame format in both directions: start 0, 8 data bits LSB first, stop 1; each bit lasts BIT_CYC clocks.
REQ-014 States: IDLE, RX_START, RX_DATA, RX_STOP, RX_WAITHI, TURN, TX_START, TX_DATA, TX_STOP.
REQ-015 IDLE: line_s=0 -> RX_START with the bit counter cleared.
REQ-016 RX_START: after BIT_CYC/2 cycles, line_s=0 -> RX_DATA; line_s=1 (false start) -> IDLE with no pulse.
REQ-017 RX_DATA: line_s is sampled every BIT_CYC cycles; 8 samples are shifted in LSB first; then -> RX_STOP.
REQ-018 RX_STOP: line_s is sampled BIT_CYC cycles after the last data sample.
- Sample 1: rx_data <= shifted byte, rx_valid pulses, tx_data latched, -> TURN.
- Sample 0: frame_err pulses, rx_data unchanged, -> RX_WAITHI.
REQ-019 RX_WAITHI: waits for line_s=1, then -> IDLE; no response is driven.
REQ-020 TURN: line released for TURN_CYC cycles after the rx_valid cycle, then -> TX_START.
REQ-021 If rx_valid is at cycle T, drive_en first rises at cycle T+TURN_CYC+1.
REQ-022 TX_START drives 0 for BIT_CYC cycles.
REQ-023 TX_DATA drives the latched byte LSB first, BIT_CYC cycles per bit.
REQ-024 TX_STOP drives 1 for BIT_CYC cycles, then drive_en falls and the FSM -> IDLE.
REQ-025 The transmit burst is exactly 10*BIT_CYC driven cycles.
REQ-026 While drive_en=1, line_s is ignored.
REQ-027 tx_data changes after the capture cycle do not affect the burst in progress.
REQ-028 Dio = drive_en ? tx_bit : Z; drive_en and tx_bit are registered (no combinational glitch on Dio).
REQ-029 The first start bit after returning to IDLE is accepted only on a fresh 1->0 transition of line_s.

Reset
REQ-030 While rst=1, immediately and asynchronously:
- FSM=IDLE, counters=0.
- rx_data=0x00, rx_valid=0, frame_err=0, drive_en=0, busy=0, Dio=Z, synchronizer flops=1.
REQ-031 Reset asserted mid-frame (receive or transmit) aborts the frame with no pulse.
REQ-032 After rst falls, operation resumes from IDLE on the next start bit.

Verification (BIT_CYC=4, TURN_CYC=2)
REQ-033 Initiator sends 0xA5 with stop 1, tx_data=0x3C -> rx_valid pulse with rx_data=0xA5; Dio Z for 2 cycles; then 40 driven cycles with bit sequence 0,0,0,1,1,1,1,0,0,1 (each bit 4 cycles); then Z.
REQ-034 Line pulled low for 1 cycle only -> no rx_valid, no frame_err; busy returns to 0 within 4 cycles; Dio stays Z.
REQ-035 Frame 0x5A with stop bit 0 -> frame_err pulse, rx_data unchanged, no drive; line returned high, then frame 0x11 -> rx_valid with 0x11 and response driven.
REQ-036 rst asserted at the 5th driven response bit -> Dio=Z and drive_en=0 in the same cycle, all outputs 0; next frame 0xFF -> rx_valid with 0xFF.
REQ-037 tx_data changed from 0x3C to 0xC3 during TX_DATA -> driven byte remains 0x3C.
REQ-038 Two back-to-back exchanges, 0x01 then 0x80 -> two rx_valid pulses with matching rx_data and two complete 40-cycle responses.
